axi_dma_mm2s_stream_sink: RTL and testbench

//  Slave AXI-Stream endpoint for the AXI DMA MM2S channel (memory -> PL). Taps AXI-Lite

---
 rtl/axi_dma_mm2s_stream_sink_pkg.sv | 14 +
 rtl/axi_dma_send_transfer_tap.sv | 43 ++++
 rtl/axi_dma_mm2s_stream_sink.sv | 172 +++++++++++++++++
 tb/tb_axi_dma_mm2s_stream_sink.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_mm2s_stream_sink_pkg.sv
// Shared definitions for the MM2S stream sink: DMA register offsets and FSM states.
package axi_dma_mm2s_stream_sink_pkg;

    localparam logic [9:0] MM2S_DMACR  = 10'h00;
    localparam logic [9:0] MM2S_LENGTH = 10'h28;
    localparam logic [9:0] S2MM_LENGTH = 10'h58;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/axi_dma_send_transfer_tap.sv
// Snoops DMA AXI-Lite writes and emits a one-cycle request pulse with the
// registered MM2S transfer length. Zero-length writes are dropped.
module axi_dma_send_transfer_tap
    import axi_dma_mm2s_stream_sink_pkg::*;
#(
    parameter int         LENGTH_WIDTH    = 26,
    parameter logic [9:0] LENGTH_REG_ADDR = MM2S_LENGTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              i_awaddr,
    input  logic [31:0]             i_wdata,
    input  logic                    i_wready,
    input  logic                    i_wvalid,
    output logic                    o_request,
    output logic [LENGTH_WIDTH-1:0] o_length
);

    logic                    w_hit;
    logic                    w_unused;
    logic                    r_request;
    logic [LENGTH_WIDTH-1:0] r_length;

    assign w_hit = i_wvalid & i_wready & (i_awaddr == LENGTH_REG_ADDR)
                 & (|i_wdata[LENGTH_WIDTH-1:0]);

    // Bits above the length field carry no meaning for the stream side.
    assign w_unused = ^i_wdata[31:LENGTH_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_request <= 1'b0;
            r_length  <= '0;
        end else begin
            r_request <= w_hit;
            if (w_hit) r_length <= i_wdata[LENGTH_WIDTH-1:0];
        end
    end

    assign o_request = r_request;
    assign o_length  = r_length;

endmodule

// File: rtl/axi_dma_mm2s_stream_sink.sv
// AXI-Stream sink for the DMA MM2S channel: forwards beats through a one-entry
// output register, checks tlast against the tapped length, reports done/errors.
module axi_dma_mm2s_stream_sink
    import axi_dma_mm2s_stream_sink_pkg::*;
#(
    parameter int         TDATA_WIDTH     = 128,
    parameter int         LENGTH_WIDTH    = 26,
    parameter logic [9:0] LENGTH_REG_ADDR = MM2S_LENGTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [9:0]               axilite_tap_awaddr,
    input  logic [31:0]              axilite_tap_wdata,
    input  logic                     axilite_tap_wready,
    input  logic                     axilite_tap_wvalid,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                     s_axis_tlast,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TDATA_WIDTH-1:0]   out_data,
    output logic [TDATA_WIDTH/8-1:0] out_keep,
    output logic [LENGTH_WIDTH-1:0]  out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err_early_last,
    output logic                     err_missing_last,
    output logic                     err_overlap,
    input  logic                     err_clear
);

    localparam int BYTES  = TDATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);

    state_t                   r_state, w_state_nxt;
    logic                     w_req;
    logic [LENGTH_WIDTH-1:0]  w_req_len;
    logic [LENGTH_WIDTH:0]    w_len_round;
    logic [LENGTH_WIDTH:0]    w_beats;
    logic                     w_busy, w_accept, w_final, w_start, w_overlap;
    logic                     w_load, w_fin, w_early, w_missing, w_out_last;

    logic [LENGTH_WIDTH-1:0]  r_cnt;
    logic [LENGTH_WIDTH:0]    r_last_idx;
    logic                     r_out_valid;
    logic [TDATA_WIDTH-1:0]   r_out_data;
    logic [BYTES-1:0]         r_out_keep;
    logic [LENGTH_WIDTH-1:0]  r_out_index;
    logic                     r_out_last;
    logic                     r_done;
    logic                     r_err_early, r_err_missing, r_err_overlap;

    axi_dma_send_transfer_tap #(
        .LENGTH_WIDTH    (LENGTH_WIDTH),
        .LENGTH_REG_ADDR (LENGTH_REG_ADDR)
    ) u_tap (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_awaddr  (axilite_tap_awaddr),
        .i_wdata   (axilite_tap_wdata),
        .i_wready  (axilite_tap_wready),
        .i_wvalid  (axilite_tap_wvalid),
        .o_request (w_req),
        .o_length  (w_req_len)
    );

    // Beats = ceil(length / BYTES); one extra bit keeps the round-up from overflowing.
    assign w_len_round = {1'b0, w_req_len} + (LENGTH_WIDTH+1)'(BYTES - 1);
    assign w_beats     = w_len_round >> BSHIFT;

    assign w_busy        = (r_state != IDLE);
    assign s_axis_tready = w_busy & (!r_out_valid | out_ready);
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_final       = ({1'b0, r_cnt} == r_last_idx);
    // A request landing on the done cycle is dropped without flagging overlap.
    assign w_start       = w_req & (r_state == IDLE) & !r_done;
    assign w_overlap     = w_req & w_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fin       = 1'b0;
        w_early     = 1'b0;
        w_missing   = 1'b0;
        w_out_last  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_state_nxt = RECV;
            end
            RECV: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    if (s_axis_tlast) begin
                        w_out_last  = 1'b1;
                        w_fin       = 1'b1;
                        w_early     = !w_final;
                        w_state_nxt = IDLE;
                    end else if (w_final) begin
                        w_out_last  = 1'b1;
                        w_missing   = 1'b1;
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_accept && s_axis_tlast) begin
                    w_fin       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_last_idx    <= '0;
            r_done        <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
            r_err_overlap <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_fin;
            if (w_start) begin
                r_cnt      <= '0;
                r_last_idx <= w_beats - (LENGTH_WIDTH+1)'(1);
            end else if (w_load) begin
                r_cnt <= r_cnt + LENGTH_WIDTH'(1);
            end
            // Set has priority over a coincident clear.
            r_err_early   <= (r_err_early   & ~err_clear) | w_early;
            r_err_missing <= (r_err_missing & ~err_clear) | w_missing;
            r_err_overlap <= (r_err_overlap & ~err_clear) | w_overlap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= s_axis_tdata;
            r_out_keep  <= s_axis_tkeep;
            r_out_index <= r_cnt;
            r_out_last  <= w_out_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;
    assign out_keep         = r_out_keep;
    assign out_index        = r_out_index;
    assign out_last         = r_out_last;
    assign busy             = w_busy;
    assign done             = r_done;
    assign err_early_last   = r_err_early;
    assign err_missing_last = r_err_missing;
    assign err_overlap      = r_err_overlap;

endmodule

// File: tb/tb_axi_dma_mm2s_stream_sink.sv
// Directed, table-driven bench for the MM2S stream sink (TDATA 128, 16 bytes/beat).
module tb_axi_dma_mm2s_stream_sink;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [9:0]   awaddr;
    logic [31:0]  wdata;
    logic         wready, wvalid;
    logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [127:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic         out_valid, out_ready, out_last;
    logic [127:0] out_data;
    logic [15:0]  out_keep;
    logic [25:0]  out_index;
    logic         busy, done, err_early_last, err_missing_last, err_overlap, err_clear;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_dma_mm2s_stream_sink dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .axilite_tap_awaddr (awaddr),
        .axilite_tap_wdata  (wdata),
        .axilite_tap_wready (wready),
        .axilite_tap_wvalid (wvalid),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tlast       (s_axis_tlast),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_keep           (out_keep),
        .out_index          (out_index),
        .out_last           (out_last),
        .busy               (busy),
        .done               (done),
        .err_early_last     (err_early_last),
        .err_missing_last   (err_missing_last),
        .err_overlap        (err_overlap),
        .err_clear          (err_clear)
    );

    typedef struct {
        logic [31:0] len;
        int          nbeats;     // beats the DMA actually sends
        int          tlast_at;   // beat carrying tlast
        logic [15:0] last_keep;  // tkeep of the final sent beat
        bit          toggle;     // out_ready alternates 1/0
        bit          ovl;        // extra length write mid-transfer
        int          exp_fwd;
        bit          exp_early;
        bit          exp_miss;
        bit          exp_ovl;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] bdata(input int v, input int k);
        logic [31:0] w;
        w = 32'hC0DE0000 | (32'(v) << 8) | 32'(k);
        return {w, ~w, w ^ 32'h5A5A5A5A, w + 32'h1};
    endfunction

    task automatic tap_write(input logic [9:0] a, input logic [31:0] d, input logic rdy);
        @(negedge clk);
        awaddr = a; wdata = d; wvalid = 1'b1; wready = rdy;
        @(negedge clk);
        wvalid = 1'b0; wready = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        #1;
        chk("errs_after_clear", {err_early_last, err_missing_last, err_overlap}, 3'b000);
    endtask

    task automatic run_vec(input int vi);
        vec_t        v;
        int          sent, fwd, dones, cyc;
        bit          ovl_done;
        logic [15:0] ek;
        v = vecs[vi];
        sent = 0; fwd = 0; dones = 0; cyc = 0; ovl_done = 0;
        tap_write(10'h28, v.len, 1'b1);
        while (1) begin
            @(negedge clk);
            out_ready = v.toggle ? ((cyc % 2) == 0) : 1'b1;
            if (v.ovl && sent == 1 && !ovl_done) begin
                awaddr = 10'h28; wdata = 32'd16; wvalid = 1'b1; wready = 1'b1;
                ovl_done = 1;
            end else begin
                wvalid = 1'b0; wready = 1'b0;
            end
            if (sent < v.nbeats) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = bdata(vi, sent);
                s_axis_tkeep  = (sent == v.nbeats - 1) ? v.last_keep : 16'hFFFF;
                s_axis_tlast  = (sent == v.tlast_at);
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
            end
            #1;
            if (done) dones++;
            if (out_valid && out_ready) begin
                ek = (fwd == v.nbeats - 1) ? v.last_keep : 16'hFFFF;
                chk($sformatf("v%0d_index", vi), out_index, fwd);
                chk($sformatf("v%0d_data%0d", vi, fwd), out_data, bdata(vi, fwd));
                chk($sformatf("v%0d_keep%0d", vi, fwd), out_keep, ek);
                chk($sformatf("v%0d_last%0d", vi, fwd), out_last, (fwd == v.exp_fwd - 1));
                fwd++;
            end
            if (s_axis_tvalid && s_axis_tready) sent++;
            cyc++;
            if (sent == v.nbeats && !busy && !out_valid) break;
            if (cyc >= 300) begin
                n_cmp++; n_bad++;
                $display("FAIL v%0d_timeout: actual sent=%0d fwd=%0d required sent=%0d", vi, sent, fwd, v.nbeats);
                break;
            end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; wvalid = 1'b0; wready = 1'b0;
        #1;
        chk($sformatf("v%0d_fwd_count", vi), fwd, v.exp_fwd);
        chk($sformatf("v%0d_done_count", vi), dones, 1);
        chk($sformatf("v%0d_err_early", vi), err_early_last, v.exp_early);
        chk($sformatf("v%0d_err_missing", vi), err_missing_last, v.exp_miss);
        chk($sformatf("v%0d_err_overlap", vi), err_overlap, v.exp_ovl);
        chk($sformatf("v%0d_tready_idle", vi), s_axis_tready, 1'b0);
        clear_errs();
    endtask

    initial begin
        //          len  nb tl keep      tog ovl fwd early miss ovl
        vecs[0] = '{64,  4, 3, 16'hFFFF, 0, 0, 4,  0, 0, 0};
        vecs[1] = '{50,  4, 3, 16'h0003, 0, 0, 4,  0, 0, 0};
        vecs[2] = '{64,  2, 1, 16'hFFFF, 0, 0, 2,  1, 0, 0};
        vecs[3] = '{32,  4, 3, 16'hFFFF, 0, 0, 2,  0, 1, 0};
        vecs[4] = '{256, 16, 15, 16'hFFFF, 1, 0, 16, 0, 0, 0};
        vecs[5] = '{1,   1, 0, 16'h0001, 0, 0, 1,  0, 0, 0};
        vecs[6] = '{17,  2, 1, 16'h0001, 1, 0, 2,  0, 0, 0};
        vecs[7] = '{64,  4, 3, 16'hFFFF, 0, 1, 4,  0, 0, 1};

        rst_n = 1'b0; awaddr = '0; wdata = '0; wready = 1'b0; wvalid = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        out_ready = 1'b0; err_clear = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs",
            {out_valid, s_axis_tready, busy, done, out_last, err_early_last, err_missing_last, err_overlap},
            8'h00);
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_out_index", out_index, 26'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_tready", s_axis_tready, 1'b0);

        // Writes that must not start a transfer
        tap_write(10'h28, 32'h0400_0000, 1'b1);
        repeat (2) @(negedge clk); #1;
        chk("zero_len_ignored", busy, 1'b0);
        tap_write(10'h58, 32'd64, 1'b1);
        repeat (2) @(negedge clk); #1;
        chk("other_addr_ignored", busy, 1'b0);
        tap_write(10'h28, 32'd64, 1'b0);
        repeat (2) @(negedge clk); #1;
        chk("no_wready_ignored", busy, 1'b0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Reset asserted with a beat buffered and an error pending
        tap_write(10'h28, 32'd256, 1'b1);
        @(negedge clk);
        out_ready = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = bdata(9, 0);
        s_axis_tkeep = 16'hFFFF; s_axis_tlast = 1'b0;
        repeat (3) @(negedge clk);
        tap_write(10'h28, 32'd64, 1'b1);
        repeat (2) @(negedge clk); #1;
        chk("pre_rst_state", {busy, out_valid, err_overlap, s_axis_tready}, 4'b1110);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs",
            {out_valid, s_axis_tready, busy, done, out_last, err_early_last, err_missing_last, err_overlap},
            8'h00);
        chk("mid_rst_data", out_data, 128'h0);
        @(negedge clk);
        s_axis_tvalid = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
